// File: rtl/id_pkg.sv
// Shared opcode and EX-control encodings for the RV32I instruction-decode stage.
package id_pkg;

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int CTRL_ALU_SRC_IMM = 7;
    localparam int CTRL_MEM_TO_REG  = 6;
    localparam int CTRL_REG_WRITE   = 5;
    localparam int CTRL_MEM_READ    = 4;
    localparam int CTRL_MEM_WRITE   = 3;
    localparam int CTRL_BRANCH      = 2;

    localparam logic [7:0] CTRL_R      = 8'h22;
    localparam logic [7:0] CTRL_IMM    = 8'hA2;
    localparam logic [7:0] CTRL_LOAD   = 8'hF0;
    localparam logic [7:0] CTRL_STORE  = 8'h88;
    localparam logic [7:0] CTRL_BRANCH_OP = 8'h05;
    localparam logic [7:0] CTRL_JAL    = 8'h24;
    localparam logic [7:0] CTRL_LUI    = 8'hA0;

endpackage

// File: rtl/id_regfile.sv
// Integer register file, 2 read / 1 write, x0 hardwired to zero.
// Define ID_WB_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module id_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RA_W = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [RA_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RA_W-1:0] raddr1,
    input  logic [RA_W-1:0] raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`ifdef ID_WB_BYPASS_EN
        // Write-then-read: the value being written back this cycle wins.
        if (we && (waddr != '0) && (waddr == raddr1)) rdata1 = wdata;
        if (we && (waddr != '0) && (waddr == raddr2)) rdata2 = wdata;
`endif
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage with ID/EX handshake, load-use interlock and flush.
// Optional ID_WB_BYPASS_EN enables writeback-to-decode forwarding in the register file.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int CTRL_W = 8,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_alu_ctrl,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [RA_W-1:0]   ex_rs1_addr,
    output logic [RA_W-1:0]   ex_rs2_addr,
    output logic [RA_W-1:0]   ex_rd_addr,
    output logic [XLEN-1:0]   ex_imm,
    output logic              ex_illegal
);

    logic [6:0]        opcode;
    logic [RA_W-1:0]   rs1_addr, rs2_addr, rd_field, dec_rd;
    logic [CTRL_W-1:0] dec_ctrl;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   dec_imm, rs1_data, rs2_data;
    logic              dec_illegal, uses_rs1, uses_rs2;
    logic              stall, load_en;

    assign opcode   = if_instr[6:0];
    assign rd_field = if_instr[7 +: RA_W];
    assign rs1_addr = if_instr[15 +: RA_W];
    assign rs2_addr = if_instr[20 +: RA_W];

    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        imm32       = '0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        case (opcode)
            OP_R: begin
                dec_ctrl = CTRL_W'(CTRL_R);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD: begin
                dec_ctrl = (opcode == OP_IMM) ? CTRL_W'(CTRL_IMM) : CTRL_W'(CTRL_LOAD);
                imm32    = {{20{if_instr[31]}}, if_instr[31:20]};
                uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec_ctrl = CTRL_W'(CTRL_STORE);
                imm32    = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                dec_ctrl = CTRL_W'(CTRL_BRANCH_OP);
                imm32    = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                            if_instr[30:25], if_instr[11:8], 1'b0};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                dec_ctrl = CTRL_W'(CTRL_JAL);
                imm32    = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0};
            end
            OP_LUI: begin
                dec_ctrl = CTRL_W'(CTRL_LUI);
                imm32    = {if_instr[31:12], 12'b0};
            end
            OP_NOP: ;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_imm = XLEN'($signed(imm32));
    assign dec_rd  = dec_ctrl[CTRL_REG_WRITE] ? rd_field : '0;

    // A load still in EX cannot forward its data in time for a dependent op.
    assign stall = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd_addr != '0) && if_valid &&
                   ((uses_rs1 && (ex_rd_addr == rs1_addr)) ||
                    (uses_rs2 && (ex_rd_addr == rs2_addr)));

    assign load_en  = (!ex_valid || ex_ready) && !stall;
    assign id_ready = load_en && !flush && rst_n;

    id_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Flush beats everything; a stall under ex_ready drains EX with a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_ctrl     <= '0;
            ex_alu_ctrl <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_imm      <= '0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_illegal <= 1'b0;
        end else if (stall) begin
            if (ex_ready) begin
                ex_valid   <= 1'b0;
                ex_ctrl    <= '0;
                ex_illegal <= 1'b0;
            end
        end else if (load_en) begin
            ex_valid <= if_valid;
            if (if_valid) begin
                ex_pc       <= if_pc;
                ex_ctrl     <= dec_ctrl;
                ex_alu_ctrl <= {if_instr[30], if_instr[25], if_instr[14:12]};
                ex_rs1_data <= rs1_data;
                ex_rs2_data <= rs2_data;
                ex_rs1_addr <= rs1_addr;
                ex_rs2_addr <= rs2_addr;
                ex_rd_addr  <= dec_rd;
                ex_imm      <= dec_imm;
                ex_illegal  <= dec_illegal;
            end else begin
                ex_ctrl    <= '0;
                ex_illegal <= 1'b0;
            end
        end
    end

endmodule
